// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: memory-responder FSM states and
// latency-counter width.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_resp_state_t;

  localparam int MEM_LAT_W = 4;

endpackage

// File: rtl/mem_responder_array.sv
// Byte-enabled word array: synchronous write, combinational read.
// Ports: clk, we, be[3:0], idx, wdata[31:0], rdata[31:0].
module mem_responder_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory endpoint for the mem_read/mem_write/mem_resp
// handshake. Ports: clk, rst (sync, active-high), mem_read, mem_write,
// mem_address, mem_byte_enable, mem_wdata, mem_resp, mem_rdata, busy.
// Optional MEM_RESPONDER_ERR_EN adds mem_err (conflict/out-of-range).
module mem_responder
  import rv32i_types::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
`ifdef MEM_RESPONDER_ERR_EN
  output logic        mem_err,
`endif
  output logic        busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("mem_responder: LATENCY must be 1..15");
  end

  localparam logic [MEM_LAT_W-1:0] LAT_M1 = MEM_LAT_W'(LATENCY - 1);

  mem_resp_state_t       state_q, state_d;
  logic [MEM_LAT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     idx_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  wr_q;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q;
  logic [31:0]           arr_rdata;
  logic                  req;
  logic                  accept;
  logic                  arr_we;
  logic                  rd_done;
  logic                  unused_addr;

  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) & req;

  // Upper address bits only matter for error flagging; low bits never.
  assign unused_addr = ^{mem_address[31:ADDR_W+2], mem_address[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
  assign err_d = (mem_read & mem_write) | (|mem_address[31:ADDR_W+2]);
`else
  assign err_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == MEM_LAT_W'(1)) state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= mem_rdata;
    end
  end

  // Request fields are captured at acceptance and ignored afterwards.
  // Both strobes high resolves to a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= mem_address[ADDR_W+1:2];
      be_q    <= mem_byte_enable;
      wdata_q <= mem_wdata;
      wr_q    <= mem_write;
      err_q   <= err_d;
    end
  end

  assign mem_resp = (state_q == RESP);
  assign busy     = (state_q != IDLE);
  assign arr_we   = mem_resp & wr_q & ~err_q;
  assign rd_done  = mem_resp & ~wr_q & ~err_q;

  // Read data is shown live during RESP and captured for holding after.
  assign mem_rdata = rd_done ? arr_rdata : rdata_q;

`ifdef MEM_RESPONDER_ERR_EN
  assign mem_err = mem_resp & err_q;
`endif

  mem_responder_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (be_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 3, 1 and 15.
// Stimulus pushes expected responses; a monitor pops and compares.
module tb_mem_responder;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wd    [3];
  logic        resp  [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
`ifdef MEM_RESPONDER_ERR_EN
  logic        err_o [3];
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   iss [3];
  bit   inflight [3];
  bit   prev_resp [3];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W (10),
      .LATENCY((g == 0) ? 3 : (g == 1) ? 1 : 15)
    ) dut (
      .clk            (clk),
      .rst            (rst[g]),
      .mem_read       (rd[g]),
      .mem_write      (wr[g]),
      .mem_address    (addr[g]),
      .mem_byte_enable(be[g]),
      .mem_wdata      (wd[g]),
      .mem_resp       (resp[g]),
      .mem_rdata      (rdata[g]),
`ifdef MEM_RESPONDER_ERR_EN
      .mem_err        (err_o[g]),
`endif
      .busy           (busy[g])
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 15;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (prev_resp[d]) chk($sformatf("resp_width%0d", d), 32'(resp[d]), 0);
      if (resp[d]) begin
        chk($sformatf("busy_resp%0d", d), 32'(busy[d]), 1);
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          chk($sformatf("unexpected_resp%0d", d), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("rdata%0d", d), rdata[d], e.rdata);
          chk($sformatf("latency%0d", d), cyc - iss[d], e.lat);
        end
        inflight[d] = 1'b0;
      end else if (inflight[d] && cyc > iss[d]) begin
        chk($sformatf("busy_flight%0d", d), 32'(busy[d]), 1);
      end
      prev_resp[d] = resp[d];
    end
  end

  task automatic req(int d, bit r, bit w, logic [31:0] a,
                     logic [3:0] b, logic [31:0] wdv,
                     logic [31:0] exp);
    exp_t e;
    int   n;
    e.dut = d; e.rdata = exp; e.lat = lat_of(d);
    @(negedge clk);
    sbq.push_back(e);
    iss[d] = cyc; inflight[d] = 1'b1;
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wd[d] = wdv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp[d] && n < 40);
    if (!resp[d]) begin
      chk($sformatf("timeout%0d", d), 0, 1);
      inflight[d] = 1'b0;
      if (sbq.size() > 0) e = sbq.pop_front();
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; be[d] = '0; wd[d] = '0;
      iss[d] = 0; inflight[d] = 1'b0; prev_resp[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_resp%0d", d), 32'(resp[d]), 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
      rst[d] = 1'b0;
    end

    req(0, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    req(0, 1, 0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF);
    req(0, 0, 1, 32'h100, 4'b0001, 32'h000000AA, 32'hDEADBEEF);
    req(0, 0, 1, 32'h100, 4'b1100, 32'h12340000, 32'hDEADBEEF);
    req(0, 1, 0, 32'h102, 4'b0000, 32'h0,        32'h1234BEAA);
    req(0, 0, 1, 32'h1000, 4'b1111, 32'h00000055, 32'h1234BEAA);
    req(0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h00000055);
    req(0, 1, 1, 32'h8,   4'b1111, 32'h00000077, 32'h00000055);
    req(0, 1, 0, 32'h8,   4'b0000, 32'h0,        32'h00000077);
    req(0, 0, 1, 32'h200, 4'b0000, 32'hFFFFFFFF, 32'h00000077);
    req(0, 0, 1, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h00000077);
    req(0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'hCAFEF00D);

    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 32'h100;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy[0]), 1);
    rd[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", 32'(busy[0]), 0);
    chk("abort_resp", 32'(resp[0]), 0);
    repeat (6) @(negedge clk);

    wr[0] = 1'b1; addr[0] = 32'h200; be[0] = 4'b1111;
    wd[0] = 32'h11111111;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy[0]), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0; wr[0] = 1'b0;
    chk("rst_mid_idle", 32'(busy[0]), 0);
    chk("rst_mid_resp", 32'(resp[0]), 0);
    chk("rst_mid_rdata", rdata[0], 0);
    repeat (6) @(negedge clk);
    req(0, 1, 0, 32'h200, 4'b0000, 32'h0, 32'hCAFEF00D);

    req(1, 0, 1, 32'h4, 4'b1111, 32'hA5A5A5A5, 32'h0);
    req(1, 1, 0, 32'h4, 4'b0000, 32'h0,        32'hA5A5A5A5);
    req(2, 0, 1, 32'h4, 4'b1111, 32'h0F0F0F0F, 32'h0);
    req(2, 1, 0, 32'h4, 4'b0000, 32'h0,        32'h0F0F0F0F);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
